load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared LSU types: FSM state encoding, access-size codes and address helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte offset actually used: halves drop Addr[0], words drop Addr[1:0].
    function automatic logic [1:0] lsu_offset(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return a;
            SZ_HALF: return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data, plus
// down-shifting of load data by the captured byte offset.
module lsu_lane_align
    import riscv_pkg::*;
#(
    parameter int N_Bits = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic [N_Bits-1:0] wdata,
    output logic [3:0]        be,
    output logic [N_Bits-1:0] wdata_lanes,
    input  logic [1:0]        rd_offset,
    input  logic [N_Bits-1:0] rdata,
    output logic [N_Bits-1:0] rdata_aligned
);

    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << offset;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be          = 4'b0011 << offset;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = wdata;
            end
        endcase
    end

    assign rdata_aligned = rdata >> {rd_offset, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/REQ/DONE bus FSM with wait-counter timeout abort.
// Optional misaligned-access trap enabled by LSU_MISALIGN_TRAP_EN.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int N_Bits  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic [N_Bits-1:0] Addr,
    input  logic [N_Bits-1:0] WriteData,
    output logic [N_Bits-1:0] ReadData,
    output logic              Stall,
    output logic              Misalign,
    output logic              BusErr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [N_Bits-1:0] bus_addr,
    output logic [N_Bits-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic [N_Bits-1:0] bus_rdata,
    input  logic              bus_ack
);

    lsu_state_t        state;
    logic [7:0]        wait_cnt;
    logic [1:0]        rd_off;
    logic [1:0]        eff_off;
    logic              req_valid;
    logic              mis;
    logic [3:0]        lane_be;
    logic [N_Bits-1:0] lane_wdata;
    logic [N_Bits-1:0] rd_aligned;

    assign req_valid = MemRead || MemWrite;
    assign eff_off   = lsu_offset(Size, Addr[1:0]);
    assign Stall     = (state == REQ) || ((state == IDLE) && req_valid);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign mis      = lsu_misaligned(Size, Addr[1:0]);
    assign Misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else
            misalign_q <= (state == IDLE) && req_valid && mis;
    end
`else
    assign mis      = 1'b0;
    assign Misalign = 1'b0;
`endif

    lsu_lane_align #(.N_Bits(N_Bits)) u_align (
        .size          (Size),
        .offset        (eff_off),
        .wdata         (WriteData),
        .be            (lane_be),
        .wdata_lanes   (lane_wdata),
        .rd_offset     (rd_off),
        .rdata         (bus_rdata),
        .rdata_aligned (rd_aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rd_off    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            ReadData  <= '0;
            BusErr    <= 1'b0;
        end else begin
            BusErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (mis) begin
                            state <= DONE;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_addr  <= {Addr[N_Bits-1:2], 2'b00};
                            bus_be    <= lane_be;
                            bus_wdata <= lane_wdata;
                            rd_off    <= eff_off;
                            wait_cnt  <= '0;
                        end
                    end
                end
                REQ: begin
                    // Ack takes priority over a coincident timeout.
                    if (bus_ack) begin
                        state    <= DONE;
                        bus_req  <= 1'b0;
                        ReadData <= rd_aligned;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state    <= DONE;
                        bus_req  <= 1'b0;
                        BusErr   <= 1'b1;
                        ReadData <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT=16).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [1:0]  Size;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, Misalign, BusErr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.N_Bits(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Misalign  (Misalign),
        .BusErr    (BusErr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00;
        Addr = '0; WriteData = '0; bus_rdata = '0; bus_ack = 1'b0;
        tick();
        tick();
        check("rst_stall",   32'(Stall),    32'd0);
        check("rst_req",     32'(bus_req),  32'd0);
        check("rst_we",      32'(bus_we),   32'd0);
        check("rst_be",      32'(bus_be),   32'd0);
        check("rst_addr",    bus_addr,      32'd0);
        check("rst_wdata",   bus_wdata,     32'd0);
        check("rst_rdata",   ReadData,      32'd0);
        check("rst_mis",     32'(Misalign), 32'd0);
        check("rst_buserr",  32'(BusErr),   32'd0);
        rst = 1'b0;
        tick();

        // Word load at 0x100, ack in the first REQ cycle
        MemRead = 1'b1; Size = 2'b10; Addr = 32'h100; #1;
        check("wl_stall_c0", 32'(Stall),   32'd1);
        check("wl_noreq_c0", 32'(bus_req), 32'd0);
        tick();
        check("wl_req_c1",   32'(bus_req), 32'd1);
        check("wl_stall_c1", 32'(Stall),   32'd1);
        check("wl_addr",     bus_addr,     32'h100);
        check("wl_we",       32'(bus_we),  32'd0);
        check("wl_be",       32'(bus_be),  32'hF);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0; bus_rdata = '0; MemRead = 1'b0; #1;
        check("wl_stall_c2", 32'(Stall),   32'd0);
        check("wl_req_c2",   32'(bus_req), 32'd0);
        check("wl_rdata",    ReadData,     32'hDEADBEEF);
        check("wl_buserr",   32'(BusErr),  32'd0);
        tick();
        check("wl_rdata_hold", ReadData,   32'hDEADBEEF);

        // Byte store at 0x203 with MemRead also high: the write wins
        MemRead = 1'b1; MemWrite = 1'b1; Size = 2'b00; Addr = 32'h203; WriteData = 32'h000000A5;
        tick();
        check("bs_we",    32'(bus_we),  32'd1);
        check("bs_be",    32'(bus_be),  32'b1000);
        check("bs_wdata", bus_wdata,    32'hA5A5A5A5);
        check("bs_addr",  bus_addr,     32'h200);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        check("bs_req_done", 32'(bus_req), 32'd0);
        tick();

        // Half load at 0x102, ack three cycles late; inputs scrambled meanwhile
        MemRead = 1'b1; Size = 2'b01; Addr = 32'h102;
        tick();
        Addr = 32'hFFFF_FFFF; Size = 2'b00; WriteData = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hl_req_wait",  32'(bus_req), 32'd1);
            check("hl_addr_wait", bus_addr,     32'h100);
            check("hl_be_wait",   32'(bus_be),  32'b1100);
            check("hl_we_wait",   32'(bus_we),  32'd0);
            check("hl_stall",     32'(Stall),   32'd1);
            tick();
        end
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_ack = 1'b0; MemRead = 1'b0;
        check("hl_rdata",  ReadData,    32'h00001234);
        check("hl_buserr", 32'(BusErr), 32'd0);
        tick();

        // Timeout: no ack for 16 REQ cycles
        MemRead = 1'b1; Size = 2'b10; Addr = 32'h300;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("to_req_wait", 32'(bus_req), 32'd1);
            check("to_no_err",   32'(BusErr),  32'd0);
            tick();
        end
        MemRead = 1'b0; #1;
        check("to_buserr", 32'(BusErr),  32'd1);
        check("to_rdata0", ReadData,     32'd0);
        check("to_req_off", 32'(bus_req), 32'd0);
        check("to_stall",  32'(Stall),   32'd0);
        tick();
        check("to_err_pulse", 32'(BusErr), 32'd0);

        // Ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_rdata", ReadData,     32'd0);
        check("idle_ack_req",   32'(bus_req), 32'd0);
        tick();

        // Ack coinciding with the last timeout cycle: ack wins
        MemRead = 1'b1; Size = 2'b10; Addr = 32'h304;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("co_still_req", 32'(bus_req), 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 1'b0; MemRead = 1'b0;
        check("co_rdata",  ReadData,    32'hCAFEF00D);
        check("co_buserr", 32'(BusErr), 32'd0);
        tick();

        // Byte load at 0x101
        MemRead = 1'b1; Size = 2'b00; Addr = 32'h101;
        tick();
        check("bl_be", 32'(bus_be), 32'b0010);
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        tick();
        bus_ack = 1'b0; MemRead = 1'b0;
        check("bl_rdata", ReadData, 32'h00112233);
        tick();

        // Reset mid-REQ, no retry afterwards
        MemRead = 1'b1; Size = 2'b10; Addr = 32'h400;
        tick();
        tick();
        check("rs_in_req", 32'(bus_req), 32'd1);
        rst = 1'b1; MemRead = 1'b0;
        tick();
        check("rs_req",   32'(bus_req), 32'd0);
        check("rs_stall", 32'(Stall),   32'd0);
        check("rs_addr",  bus_addr,     32'd0);
        check("rs_rdata", ReadData,     32'd0);
        rst = 1'b0;
        tick();
        check("rs_no_retry", 32'(bus_req), 32'd0);

        // Word load at 0x102
        MemRead = 1'b1; Size = 2'b10; Addr = 32'h102; bus_rdata = 32'hA1B2C3D4; #1;
        check("ml_stall_c0", 32'(Stall), 32'd1);
        tick();
`ifdef LSU_MISALIGN_TRAP_EN
        MemRead = 1'b0;
        check("ml_misalign", 32'(Misalign), 32'd1);
        check("ml_noreq",    32'(bus_req),  32'd0);
        tick();
        check("ml_mis_pulse", 32'(Misalign), 32'd0);
        check("ml_noreq2",    32'(bus_req),  32'd0);
`else
        check("ml_misalign", 32'(Misalign), 32'd0);
        check("ml_req",      32'(bus_req),  32'd1);
        check("ml_addr",     bus_addr,      32'h100);
        check("ml_be",       32'(bus_be),   32'hF);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; MemRead = 1'b0;
        check("ml_rdata", ReadData, 32'hA1B2C3D4);
        check("ml_mis_done", 32'(Misalign), 32'd0);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
